mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter.sv | 62 ++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline request/response and unified-memory handshake bundle
interface mem_port_arbiter_if;
  logic        InstrReqF;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        MemStallF;
  logic        DataReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master (
    input  InstrReqF, PCF, DataReqM, MemWriteM, ALUOutM, WriteDataM, mem_rdata, mem_ready,
    output InstrF, MemStallF, ReadDataM, MemStallM, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output InstrReqF, PCF, DataReqM, MemWriteM, ALUOutM, WriteDataM, mem_rdata, mem_ready,
    input  InstrF, MemStallF, ReadDataM, MemStallM, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and memory-stage accesses onto one variable-latency memory port
module mem_port_arbiter (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IDONE, DDONE} state_t;
  state_t state;
  logic last_grant;
  logic grant_d;
  // data wins unless it was the most recent grant and fetch is also waiting
  assign grant_d = bus.DataReqM & (~bus.InstrReqF | ~last_grant);
  assign bus.MemStallF = bus.InstrReqF & (state != IDONE);
  assign bus.MemStallM = bus.DataReqM & (state != DDONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.InstrF <= '0;
      bus.ReadDataM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= DBUSY;
            last_grant <= 1'b1;
            bus.mem_req <= 1'b1;
            bus.mem_we <= bus.MemWriteM;
            bus.mem_addr <= bus.ALUOutM;
            bus.mem_wdata <= bus.WriteDataM;
          end else if (bus.InstrReqF) begin
            state <= IBUSY;
            last_grant <= 1'b0;
            bus.mem_req <= 1'b1;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= bus.PCF;
          end
        end
        IBUSY: begin
          if (bus.mem_ready) begin
            state <= IDONE;
            bus.mem_req <= 1'b0;
            bus.InstrF <= bus.mem_rdata;
          end
        end
        DBUSY: begin
          if (bus.mem_ready) begin
            state <= DDONE;
            bus.mem_req <= 1'b0;
            bus.mem_we <= 1'b0;
            if (!bus.mem_we) bus.ReadDataM <= bus.mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
